smi_request_type_router: RTL and testbench
==========================================

// Module: smi_request_type_router
// PURPOSE
// - Sits directly upstream of the SMI-to-AXI write and read adaptors.
// - Takes one combined SMI request stream, decodes the frame type byte in the first word of each frame, and steers the whole frame to the write-request or read-request output.
// - Frames with an unrecognised type byte are consumed and discarded, so each adaptor only ever sees frames of its own type.
// PARAMETERS
// - DataIndexSize  4      bytes per word = 1<<DataIndexSize; DataWidth = 8*(1<<DataIndexSize), minimum 128
// - WriteReqId     8'h01  frame type byte routed to the write output
// - ReadReqId      8'h02  frame type byte routed to the read output
// PORTS
// - clk          in   1          clock
// - srst         in   1          reset: synchronous, active-high
// - smiInReady   in   1          input word valid
// - smiInEofc    in   8          0 = mid-frame word; nonzero = last word, value = valid byte count
// - smiInData    in   DataWidth  input word; frame type is bits [7:0] of the first word
// - smiInStop    out  1          backpressure to the upstream source
// - smiWrReady   out  1          write output word valid
// - smiWrEofc    out  8          write output end-of-frame / byte count
// - smiWrData    out  DataWidth  write output word
// - smiWrStop    in   1          backpressure from the write adaptor
// - smiRdReady   out  1          read output word valid
// - smiRdEofc    out  8          read output end-of-frame / byte count
// - smiRdData    out  DataWidth  read output word
// - smiRdStop    in   1          backpressure from the read adaptor
// - dropCount    out  16         discarded-frame count; exists only with SMI_ROUTER_DROP_COUNT_EN
// BEHAVIOUR
// - Transfers: a word transfers when Ready=1 and Stop=0 in the same cycle.
// - State machine, reset state Idle:
//   - Idle: routing for the current input word comes from smiInData[7:0].
//     - WriteReqId -> write output; ReadReqId -> read output; any other value -> discard.
//     - If the word transfers with eofc==0, move to Write, Read or Discard respectively.
//     - If it transfers with eofc!=0 (single-word frame), stay in Idle.
//   - Write / Read / Discard: every transferred word follows the same route.
//     - The word with eofc!=0 returns the FSM to Idle.
//     - The type byte is not re-decoded on these words.
// - Output stages: one register stage per output (valid, eofc, data).
//   - Latency: input transfer to output Ready = 1 cycle.
//   - Throughput: one word per cycle when downstream Stop=0.
//   - An output register loads when its valid flag is clear, or when it is emptying in the same cycle.
//   - Held data and eofc are stable while Ready=1 and Stop=1.
// - smiInStop: equals the selected output's (valid_q & downstream Stop).
//   - The unselected output's stall never blocks the input.
//   - In Discard, and for an unknown type in Idle, smiInStop=0; words are consumed at one per cycle.
// - The type byte is forwarded unchanged in the first word; the downstream adaptor re-reads it.
// - Reset: srst sets state to Idle and clears smiWrReady and smiRdReady to 0.
//   - smiInStop is 0 after reset (both outputs are empty).
//   - dropCount resets to 0.
//   - Data and eofc registers are not reset.
//   - srst mid-frame abandons that frame. The next input word is decoded as a new frame header; upstream is reset by the same srst.
// - Simultaneous events: an output may empty and reload in the same cycle.
//   - A write-output stall while in Read does not affect the read flow, and vice versa.
// CONFIGURATION
// - SMI_ROUTER_DROP_COUNT_EN defined: dropCount port present.
//   - Increments by 1 on the cycle the header word of a discarded frame transfers.
//   - Saturates at 16'hFFFF.
// - Not defined: port absent, no counter logic. Discard behaviour is otherwise identical.
// TESTING
// - Frame type 8'h01, 3 words (eofc 0,0,16), Stop held low:
//   - write output shows the 3 words on consecutive cycles, 1 cycle late;
//   - smiRdReady stays 0 throughout.
// - Single-word type-8'h02 frame with eofc=12, then a type-8'h01 frame on the next cycle:
//   - read output gets 1 word with eofc=12;
//   - the write output gets the following frame; no dead cycle between them.
// - Type 8'h7F, 4 words:
//   - no output Ready asserts; smiInStop=0 throughout;
//   - dropCount goes 0->1 (macro defined).
// - Write frame in progress, smiWrStop=1 for 5 cycles:
//   - smiInStop=1 while the write output holds a word;
//   - smiWrData and smiWrEofc are stable;
//   - no word is lost or duplicated after release.
// - smiRdStop=1 permanently while a type-8'h01 frame arrives:
//   - the write frame completes unaffected.
// - srst pulsed after 2 of 4 words of a write frame:
//   - both Ready outputs are 0 the next cycle;
//   - the next input word, type 8'h02, is routed to the read output.

Source files
------------

// File: rtl/smi_request_type_router.sv
// Steers each SMI request frame to the write or read adaptor by its first-word type byte; unknown types are discarded.
// Optional SMI_ROUTER_DROP_COUNT_EN adds a saturating dropCount of discarded frames.
module smi_request_type_router #(
    parameter int         DataIndexSize = 4,
    parameter logic [7:0] WriteReqId    = 8'h01,
    parameter logic [7:0] ReadReqId     = 8'h02,
    localparam int        DataWidth     = 8 * (1 << DataIndexSize)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 smiInReady,
    input  logic [7:0]           smiInEofc,
    input  logic [DataWidth-1:0] smiInData,
    output logic                 smiInStop,
    output logic                 smiWrReady,
    output logic [7:0]           smiWrEofc,
    output logic [DataWidth-1:0] smiWrData,
    input  logic                 smiWrStop,
    output logic                 smiRdReady,
    output logic [7:0]           smiRdEofc,
    output logic [DataWidth-1:0] smiRdData,
    input  logic                 smiRdStop
`ifdef SMI_ROUTER_DROP_COUNT_EN
    ,
    output logic [15:0]          dropCount
`endif
);

    if (DataIndexSize < 4) begin : gWidthCheck
        $error("smi_request_type_router: DataWidth must be at least 128 bits");
    end

    typedef enum logic [1:0] {Idle, Write, Read, Discard} state_t;

    state_t                 state_p0;
    logic                   routeWr;
    logic                   routeRd;
    logic                   inXfer;
    logic                   wrLoad;
    logic                   rdLoad;
    logic                   vldWr_p1;
    logic                   vldRd_p1;
    logic [7:0]             wrEofc_p1;
    logic [7:0]             rdEofc_p1;
    logic [DataWidth-1:0]   wrData_p1;
    logic [DataWidth-1:0]   rdData_p1;

    // Stage 0: route decode (header byte in Idle, sticky route mid-frame) and input handshake
    always_comb begin
        routeWr = 1'b0;
        routeRd = 1'b0;
        case (state_p0)
            Idle: begin
                routeWr = (smiInData[7:0] == WriteReqId);
                routeRd = (smiInData[7:0] == ReadReqId);
            end
            Write:   routeWr = 1'b1;
            Read:    routeRd = 1'b1;
            default: ;
        endcase
    end

    assign smiInStop = (routeWr & vldWr_p1 & smiWrStop) | (routeRd & vldRd_p1 & smiRdStop);
    assign inXfer    = smiInReady & ~smiInStop;
    assign wrLoad    = inXfer & routeWr;
    assign rdLoad    = inXfer & routeRd;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_p0 <= Idle;
        end else if (inXfer) begin
            if (smiInEofc != 8'd0) begin
                state_p0 <= Idle;
            end else if (state_p0 == Idle) begin
                state_p0 <= routeWr ? Write : (routeRd ? Read : Discard);
            end
        end
    end

    // Stage 1: per-output register; reloads when empty or emptying this cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            vldWr_p1 <= 1'b0;
            vldRd_p1 <= 1'b0;
        end else begin
            if (wrLoad)          vldWr_p1 <= 1'b1;
            else if (!smiWrStop) vldWr_p1 <= 1'b0;
            if (rdLoad)          vldRd_p1 <= 1'b1;
            else if (!smiRdStop) vldRd_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wrLoad) begin
            wrEofc_p1 <= smiInEofc;
            wrData_p1 <= smiInData;
        end
        if (rdLoad) begin
            rdEofc_p1 <= smiInEofc;
            rdData_p1 <= smiInData;
        end
    end

    assign smiWrReady = vldWr_p1;
    assign smiWrEofc  = wrEofc_p1;
    assign smiWrData  = wrData_p1;
    assign smiRdReady = vldRd_p1;
    assign smiRdEofc  = rdEofc_p1;
    assign smiRdData  = rdData_p1;

`ifdef SMI_ROUTER_DROP_COUNT_EN
    logic        hdrDrop;
    logic [15:0] dropCnt_p1;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hdrDrop = inXfer & (state_p0 == Idle) & ~routeWr & ~routeRd;

    always_ff @(posedge clk) begin
        if (srst)         dropCnt_p1 <= 16'd0;
        else if (hdrDrop) dropCnt_p1 <= satInc(dropCnt_p1);
    end

    assign dropCount = dropCnt_p1;
`endif

endmodule

// File: tb/tb_smi_request_type_router.sv
// Scoreboard bench for smi_request_type_router: frames are queued per destination as they are accepted,
// and a negedge monitor checks every presented word, its latency, and hold stability under Stop.
module tb_smi_request_type_router;
    localparam int W = 128;
    typedef logic [W+7:0] val_t;

    logic         clk = 1'b0;
    logic         srst = 1'b1;
    logic         smiInReady = 1'b0;
    logic [7:0]   smiInEofc = 8'd0;
    logic [W-1:0] smiInData = '0;
    logic         smiInStop;
    logic         smiWrReady;
    logic [7:0]   smiWrEofc;
    logic [W-1:0] smiWrData;
    logic         smiWrStop = 1'b0;
    logic         smiRdReady;
    logic [7:0]   smiRdEofc;
    logic [W-1:0] smiRdData;
    logic         smiRdStop = 1'b0;
`ifdef SMI_ROUTER_DROP_COUNT_EN
    logic [15:0]  dropCount;
`endif

    smi_request_type_router dut (
        .clk(clk), .srst(srst),
        .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
        .smiWrReady(smiWrReady), .smiWrEofc(smiWrEofc), .smiWrData(smiWrData), .smiWrStop(smiWrStop),
        .smiRdReady(smiRdReady), .smiRdEofc(smiRdEofc), .smiRdData(smiRdData), .smiRdStop(smiRdStop)
`ifdef SMI_ROUTER_DROP_COUNT_EN
        , .dropCount(dropCount)
`endif
    );

    typedef struct {
        logic [7:0]   eofc;
        logic [W-1:0] data;
        time          t;
    } exp_t;

    exp_t         wrQ[$];
    exp_t         rdQ[$];
    int           nVec = 0;
    int           nErr = 0;
    int           expDrop = 0;
    bit           wrStopForce = 0;
    bit           rdStopForce = 0;
    bit           randomStop = 0;
    bit           held[2];
    logic [7:0]   heldEofc[2];
    logic [W-1:0] heldData[2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input val_t act, input val_t exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name, input string msg);
        nVec++;
        nErr++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Downstream Stop generator, updated after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            smiWrStop = wrStopForce | (randomStop && ($urandom_range(2) == 0));
            smiRdStop = rdStopForce | (randomStop && ($urandom_range(2) == 0));
        end
    end

    task automatic checkPort(input int p, input logic rdy, input logic stp,
                             input logic [7:0] eofc, input logic [W-1:0] data);
        exp_t  e;
        bit    have;
        string nm;
        nm = (p == 0) ? "wr" : "rd";
        if (rdy) begin
            if (held[p]) begin
                chk({nm, "_held_stable"}, val_t'({eofc, data}), val_t'({heldEofc[p], heldData[p]}));
            end else begin
                have = (p == 0) ? (wrQ.size() > 0) : (rdQ.size() > 0);
                if (!have) begin
                    failNote({nm, "_spurious_word"}, $sformatf("got ready eofc=%h data=%h, expected no word", eofc, data));
                end else begin
                    if (p == 0) e = wrQ[0];
                    else        e = rdQ[0];
                    chk({nm, "_eofc"}, val_t'(eofc), val_t'(e.eofc));
                    chk({nm, "_data"}, val_t'(data), val_t'(e.data));
                    chk({nm, "_latency_time"}, val_t'($time), val_t'(e.t + 5));
                end
            end
            heldEofc[p] = eofc;
            heldData[p] = data;
            held[p] = stp;
            if (!stp) begin
                if (p == 0 && wrQ.size() > 0) void'(wrQ.pop_front());
                if (p == 1 && rdQ.size() > 0) void'(rdQ.pop_front());
            end
        end else begin
            if (held[p]) failNote({nm, "_held_lost"}, "ready dropped while stop was high, expected word held");
            held[p] = 0;
        end
    endtask

    // Monitor
    initial begin
        held[0] = 0;
        held[1] = 0;
        forever begin
            @(negedge clk);
            if (srst) begin
                held[0] = 0;
                held[1] = 0;
            end else begin
                checkPort(0, smiWrReady, smiWrStop, smiWrEofc, smiWrData);
                checkPort(1, smiRdReady, smiRdStop, smiRdEofc, smiRdData);
            end
        end
    end

    task automatic toEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one word until accepted; route 0 = write, 1 = read, 2 = discard
    task automatic sendWord(input int route, input logic [7:0] eofc, input logic [W-1:0] d, input bit hdr);
        bit   acc;
        bit   done;
        logic expStop;
        exp_t e;
        done = 0;
        smiInReady = 1'b1;
        smiInEofc  = eofc;
        smiInData  = d;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            expStop = (route == 0) ? (smiWrReady & smiWrStop) :
                      (route == 1) ? (smiRdReady & smiRdStop) : 1'b0;
            chk("in_stop", val_t'(smiInStop), val_t'(expStop));
            acc = !smiInStop;
            @(posedge clk);
            if (acc) begin
                done = 1;
                e.eofc = eofc;
                e.data = d;
                e.t    = $time;
                if (route == 0) wrQ.push_back(e);
                if (route == 1) rdQ.push_back(e);
                if (route == 2 && hdr && expDrop < 65535) expDrop++;
            end
        end
        if (!done) begin
            failNote("in_accept_timeout", "word not accepted within 2000 cycles, expected acceptance");
            $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
            $fatal(1, "input stalled");
        end
        #1;
        smiInReady = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] typ, input int n, input logic [7:0] lastEofc);
        int           route;
        logic [W-1:0] d;
        route = (typ == 8'h01) ? 0 : (typ == 8'h02) ? 1 : 2;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) d[7:0] = typ;
            sendWord(route, (i == n - 1) ? lastEofc : 8'd0, d, i == 0);
        end
    endtask

    task automatic checkDrop(input string name);
`ifdef SMI_ROUTER_DROP_COUNT_EN
        chk(name, val_t'(dropCount), val_t'(expDrop));
`else
        if (name.len() == 0) $display("%s", name);
`endif
    endtask

    initial begin
        logic [W-1:0] d;
        logic [7:0]   typ;
        int           pick;

        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        chk("reset_wr_ready", val_t'(smiWrReady), val_t'(0));
        chk("reset_rd_ready", val_t'(smiRdReady), val_t'(0));
        chk("reset_in_stop", val_t'(smiInStop), val_t'(0));
        checkDrop("reset_drop_count");
        toEdge();

        // Write frame, back-to-back words, no stalls
        sendFrame(8'h01, 3, 8'd16);
        idle(3);

        // Single-word read frame immediately followed by a write frame
        sendFrame(8'h02, 1, 8'd12);
        sendFrame(8'h01, 2, 8'd5);
        idle(3);

        // Unknown type is consumed and discarded
        sendFrame(8'h7F, 4, 8'd16);
        idle(2);
        @(negedge clk);
        checkDrop("drop_count_after_discard");
        toEdge();

        // Write stall for 5 cycles mid-frame
        fork
            sendFrame(8'h01, 5, 8'd9);
            begin
                repeat (2) @(posedge clk);
                #1 wrStopForce = 1;
                repeat (5) @(posedge clk);
                #1 wrStopForce = 0;
            end
        join
        idle(3);

        // Read output permanently stalled while a write frame passes
        rdStopForce = 1;
        sendFrame(8'h01, 4, 8'd7);
        idle(3);
        rdStopForce = 0;
        idle(1);

        // Reset mid-frame abandons the frame; next word is a fresh header
        d = {$urandom, $urandom, $urandom, $urandom};
        d[7:0] = 8'h01;
        sendWord(0, 8'd0, d, 1);
        d = {$urandom, $urandom, $urandom, $urandom};
        sendWord(0, 8'd0, d, 0);
        srst = 1'b1;
        wrQ.delete();
        rdQ.delete();
        expDrop = 0;
        @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        chk("post_srst_wr_ready", val_t'(smiWrReady), val_t'(0));
        chk("post_srst_rd_ready", val_t'(smiRdReady), val_t'(0));
        chk("post_srst_in_stop", val_t'(smiInStop), val_t'(0));
        checkDrop("post_srst_drop_count");
        toEdge();
        sendFrame(8'h02, 2, 8'd4);
        idle(3);

        // Randomized traffic with random downstream stalls
        randomStop = 1;
        repeat (250) begin
            pick = $urandom_range(9);
            if (pick < 4)      typ = 8'h01;
            else if (pick < 8) typ = 8'h02;
            else               typ = 8'($urandom_range(255));
            sendFrame(typ, $urandom_range(1, 5), 8'($urandom_range(1, 16)));
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end

        randomStop = 0;
        for (int k = 0; k < 50 && (wrQ.size() > 0 || rdQ.size() > 0); k++) @(posedge clk);
        @(negedge clk);
        chk("drain_wr_queue", val_t'(wrQ.size()), val_t'(0));
        chk("drain_rd_queue", val_t'(rdQ.size()), val_t'(0));
        checkDrop("final_drop_count");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
